i2c_cmd_sequencer: RTL and testbench

//  Upstream command stage for the single-byte I2C master. Queues CPU/bus I2C transactions
//  (7-bit addr, R/W, write byte) in a small FIFO and hands them one at a time to the master:
//  one-cycle newd pulse, wait for busy, wait for done. Returns one response per command
//  (read byte, ACK error, timeout flag) through a valid/ready port. Decouples the SoC bus

---
 rtl/i2c_cmd_sequencer.sv | 126 ++++++++++++
 tb/tb_i2c_cmd_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_sequencer.sv
// Command queue in front of the single-byte I2C master: buffers commands, issues them one at a
// time, and returns exactly one response per command, in order, with a timeout safety net.
module i2c_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16384
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_op,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       rsp_ack_err,
    output logic       rsp_timeout,
    output logic       seq_idle,
    output logic       m_newd,
    output logic [6:0] m_addr,
    output logic       m_op,
    output logic [7:0] m_din,
    input  logic [7:0] m_dout,
    input  logic       m_busy,
    input  logic       m_ack_err,
    input  logic       m_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef struct packed {
        logic [6:0] addr;
        logic       op;
        logic [7:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE} state_t;

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;
    logic [TW-1:0] timer;
    state_t        state;

    logic push, pop, in_wait, finish, idle_nxt, rsp_valid_nxt;

    always_comb begin
        push          = cmd_valid && cmd_ready;
        pop           = (state == S_IDLE) && (count != '0) && !rsp_valid && !m_busy;
        in_wait       = (state == S_WAIT_BUSY) || (state == S_WAIT_DONE);
        finish        = in_wait && (m_done || (timer == TW'(TIMEOUT - 1)));
        count_nxt     = count + CW'(push) - CW'(pop);
        idle_nxt      = ((state == S_IDLE) && !pop) || finish;
        rsp_valid_nxt = finish || (rsp_valid && !rsp_ready);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{addr: cmd_addr, op: cmd_op, wdata: cmd_wdata};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            timer       <= '0;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_ack_err <= 1'b0;
            rsp_timeout <= 1'b0;
            seq_idle    <= 1'b1;
            m_newd      <= 1'b0;
            m_addr      <= '0;
            m_op        <= 1'b0;
            m_din       <= '0;
        end else begin
            count     <= count_nxt;
            cmd_ready <= (count_nxt != CW'(DEPTH));
            seq_idle  <= (count_nxt == '0) && idle_nxt && !rsp_valid_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (pop) begin
                        m_addr <= mem[rd_ptr].addr;
                        m_op   <= mem[rd_ptr].op;
                        m_din  <= mem[rd_ptr].wdata;
                        m_newd <= 1'b1;
                        timer  <= '0;
                        state  <= S_ISSUE;
                    end
                end
                // Timer also ticks here so the timeout lands exactly TIMEOUT cycles after newd.
                S_ISSUE: begin
                    m_newd <= 1'b0;
                    timer  <= timer + 1'b1;
                    state  <= S_WAIT_BUSY;
                end
                default: begin
                    if (m_done) begin
                        rsp_rdata   <= m_op ? m_dout : 8'h00;
                        rsp_ack_err <= m_ack_err;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= S_IDLE;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        rsp_rdata   <= 8'h00;
                        rsp_ack_err <= 1'b0;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                        if (state == S_WAIT_BUSY && m_busy) state <= S_WAIT_DONE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer with a behavioural I2C master model that ACKs every
// address except 0x11, returns 0x3C for 0x68 and {addr,1} for other reads, or hangs on demand.
module tb_i2c_cmd_sequencer;
    localparam int DEPTH = 4, TIMEOUT = 32;

    logic clk = 1'b0, rst = 1'b1;
    logic cmd_valid = 1'b0, cmd_ready, cmd_op = 1'b0;
    logic [6:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic rsp_valid, rsp_ready = 1'b0, rsp_ack_err, rsp_timeout, seq_idle;
    logic [7:0] rsp_rdata;
    logic m_newd, m_op;
    logic [6:0] m_addr;
    logic [7:0] m_din;
    logic [7:0] m_dout = '0;
    logic m_busy = 1'b0, m_ack_err = 1'b0, m_done = 1'b0;

    i2c_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_op(cmd_op),
        .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_ack_err(rsp_ack_err), .rsp_timeout(rsp_timeout),
        .seq_idle(seq_idle), .m_newd(m_newd), .m_addr(m_addr), .m_op(m_op), .m_din(m_din),
        .m_dout(m_dout), .m_busy(m_busy), .m_ack_err(m_ack_err), .m_done(m_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    int newd_cnt = 0, newd_cyc = 0;
    logic hang = 1'b0;
    logic [15:0] issued[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_newd) begin
            issued.push_back({m_addr, m_op, m_din});
            newd_cnt = newd_cnt + 1;
            newd_cyc = cyc;
        end
    end

    // Behavioural master: busy two cycles after newd, done five cycles later.
    initial begin
        logic [6:0] a;
        forever begin
            @(negedge clk);
            if (m_newd) begin
                a = m_addr;
                if (hang) begin
                    m_busy = 1'b1;
                    while (!rst) @(negedge clk);
                    m_busy = 1'b0;
                end else begin
                    repeat (2) @(negedge clk);
                    m_busy = 1'b1;
                    repeat (5) @(negedge clk);
                    m_dout    = (a == 7'h68) ? 8'h3C : {a, 1'b1};
                    m_ack_err = (a == 7'h11);
                    m_done    = 1'b1;
                    @(negedge clk);
                    m_done    = 1'b0;
                    m_busy    = 1'b0;
                    m_ack_err = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [6:0] a, input logic op, input logic [7:0] d);
        logic acc;
        acc = 1'b0;
        cmd_addr = a; cmd_op = op; cmd_wdata = d; cmd_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            acc = cmd_ready;
            @(negedge clk);
            if (acc) break;
        end
        cmd_valid = 1'b0;
        if (!acc) chk("push_wait", 0, 1);
    endtask

    task automatic get_rsp(output logic [7:0] rd, output logic ae, output logic to);
        int i;
        rd = '0; ae = 1'b0; to = 1'b0;
        for (i = 0; i < 300 && !rsp_valid; i++) @(negedge clk);
        if (!rsp_valid) begin
            chk("rsp_wait", 0, 1);
        end else begin
            rd = rsp_rdata; ae = rsp_ack_err; to = rsp_timeout;
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, cmd_ready, 1);
        chk({tag, "_rvalid"}, rsp_valid, 0);
        chk({tag, "_rsp"}, {rsp_rdata, rsp_ack_err, rsp_timeout}, 0);
        chk({tag, "_m"}, {m_newd, m_addr, m_op, m_din}, 0);
        chk({tag, "_idle"}, seq_idle, 1);
    endtask

    initial begin
        logic [7:0] rd, r0;
        logic ae, to;
        int base;

        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        // 1: write 0x50/0xA5, newd two cycles after the push cycle
        base = newd_cnt;
        push(7'h50, 1'b0, 8'hA5);
        chk("t1_newd_n1", m_newd, 0);
        chk("t1_busy_idle", seq_idle, 0);
        @(negedge clk);
        chk("t1_newd_n2", m_newd, 1);
        chk("t1_cmd", {m_addr, m_op, m_din}, {7'h50, 1'b0, 8'hA5});
        @(negedge clk);
        chk("t1_newd_pulse", m_newd, 0);
        get_rsp(rd, ae, to);
        chk("t1_rsp", {rd, ae, to}, {8'h00, 1'b0, 1'b0});
        chk("t1_newd_cnt", newd_cnt - base, 1);
        repeat (2) @(negedge clk);
        chk("t1_idle", seq_idle, 1);

        // 2: read 0x68 -> 0x3C
        push(7'h68, 1'b1, 8'hFF);
        get_rsp(rd, ae, to);
        chk("t2_rsp", {rd, ae, to}, {8'h3C, 1'b0, 1'b0});

        // 3: NACK at 0x11, following read still issues
        base = newd_cnt;
        push(7'h11, 1'b0, 8'h01);
        push(7'h22, 1'b1, 8'h00);
        get_rsp(rd, ae, to);
        chk("t3_nack", {rd, ae, to}, {8'h00, 1'b1, 1'b0});
        get_rsp(rd, ae, to);
        chk("t3_next", {rd, ae, to}, {8'h45, 1'b0, 1'b0});
        chk("t3_order", issued[base + 1][15:9], 7'h22);

        // 4: DEPTH+1 pushes while the first is in flight, then one held off
        base = newd_cnt;
        for (int i = 0; i <= DEPTH; i++) push(7'(8'h20 + i), 1'b1, 8'h00);
        chk("t4_full", cmd_ready, 0);
        fork
            push(7'h25, 1'b1, 8'h00);
            begin
                repeat (3) @(negedge clk);
                chk("t4_held", {cmd_ready, cmd_valid}, 2'b01);
                get_rsp(rd, ae, to);
                chk("t4_rsp0", rd, 8'h41);
            end
        join
        for (int i = 1; i <= DEPTH + 1; i++) begin
            get_rsp(rd, ae, to);
            chk($sformatf("t4_rsp%0d", i), rd, {7'(8'h20 + i), 1'b1});
        end
        for (int i = 0; i <= DEPTH + 1; i++)
            chk($sformatf("t4_order%0d", i), issued[base + i][15:9], 7'(8'h20 + i));

        // 5: responses held back block further issues
        base = newd_cnt;
        for (int i = 0; i < 3; i++) push(7'(8'h30 + i), 1'b1, 8'h00);
        repeat (40) @(negedge clk);
        chk("t5_one_issue", newd_cnt - base, 1);
        chk("t5_valid", rsp_valid, 1);
        r0 = rsp_rdata;
        repeat (10) @(negedge clk);
        chk("t5_stable", {rsp_valid, rsp_rdata, rsp_ack_err, rsp_timeout}, {1'b1, 8'h61, 2'b00});
        chk("t5_stable_r0", r0, 8'h61);
        chk("t5_still_one", newd_cnt - base, 1);
        for (int i = 0; i < 3; i++) begin
            get_rsp(rd, ae, to);
            chk($sformatf("t5_rsp%0d", i), rd, {7'(8'h30 + i), 1'b1});
        end

        // 6: hung master -> timeout exactly TIMEOUT cycles after newd, then reset mid-queue
        hang = 1'b1;
        push(7'h40, 1'b0, 8'h77);
        for (int i = 0; i < 200 && !rsp_valid; i++) @(negedge clk);
        chk("t6_valid", rsp_valid, 1);
        chk("t6_latency", cyc - newd_cyc, TIMEOUT);
        chk("t6_rsp", {rsp_rdata, rsp_ack_err, rsp_timeout}, {8'h00, 1'b0, 1'b1});
        push(7'h41, 1'b0, 8'h01);
        push(7'h42, 1'b0, 8'h02);
        chk("t6_not_idle", seq_idle, 0);
        base = newd_cnt;
        rst = 1'b1;
        hang = 1'b0;
        @(negedge clk);
        chk_reset("t6_reset");
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("t6_dropped", newd_cnt - base, 0);
        chk("t6_idle", seq_idle, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
